// File: rtl/rv_lsu_pkg.sv
// Shared types and helpers for the load/store unit.
//   lsu_size_t  : access size decoded from funct3[1:0] (byte/half/word/double)
//   lsu_state_t : transaction FSM states
//   funct3 constants for loads (LB..LWU) and stores (SB..SD)
//   is_legal()  : decides whether a funct3/direction pair is a legal access
package rv_lsu_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } lsu_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SD  = 3'b011;

    // 111 is never legal, stores have no unsigned form, and doubleword
    // accesses only exist on a 64-bit bus.
    function automatic logic is_legal(input logic [2:0] funct3, input logic we, input int xlen);
        logic ok;
        ok = 1'b1;
        if (funct3 == 3'b111)                    ok = 1'b0;
        if (we && funct3[2])                     ok = 1'b0;
        if (xlen == 32 && funct3[1:0] == 2'b11)  ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/core_lsu_align.sv
// Combinational lane steering for the LSU.
//   size     in   access size
//   off      in   byte offset inside the bus word
//   wdata    in   right-aligned store data
//   uns      in   1 = zero-extend loads, 0 = sign-extend
//   rbytes   in   two bus words of read data, beat1 word in the upper half
//   mask     out  2*NB byte-lane mask; low half for beat0, high half for beat1
//   wdata_sh out  store data shifted onto lanes across two words
//   rdata    out  extracted and extended load result
module core_lsu_align
    import rv_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  lsu_size_t                    size,
    input  logic [$clog2(XLEN/8)-1:0]    off,
    input  logic [XLEN-1:0]              wdata,
    input  logic                         uns,
    input  logic [2*XLEN-1:0]            rbytes,
    output logic [2*XLEN/8-1:0]          mask,
    output logic [2*XLEN-1:0]            wdata_sh,
    output logic [XLEN-1:0]              rdata
);

    localparam int NB = XLEN / 8;

    int              nbytes;
    logic [XLEN-1:0] rsh;
    logic            sbit;

    // Illegal doubleword sizes on a 32-bit bus are clamped so the mask
    // stays in range; such requests never reach the bus anyway.
    always_comb begin
        nbytes = 1 << size;
        if (nbytes > NB) nbytes = NB;
    end

    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < nbytes) mask[i] = 1'b1;
        end
        mask = mask << off;
    end

    assign wdata_sh = {{XLEN{1'b0}}, wdata} << {off, 3'b000};

    assign rsh = XLEN'(rbytes >> {off, 3'b000});

    always_comb begin
        sbit = 1'b0;
        for (int i = 0; i < XLEN; i++) begin
            if (i == 8 * nbytes - 1) sbit = rsh[i];
        end
        for (int i = 0; i < XLEN; i++) begin
            rdata[i] = (i < 8 * nbytes) ? rsh[i] : (sbit & ~uns);
        end
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit between the memory stage and a word-wide data bus.
// One transaction at a time; boundary-crossing accesses become two bus
// beats (MISALIGN_EN=1) or are rejected with o_misaligned (MISALIGN_EN=0).
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_valid / o_ready   request handshake; i_we, i_funct3, i_addr, i_wdata
//   o_done              1-cycle completion pulse; o_rdata holds last load result
//   o_misaligned        1-cycle pulse for a rejected crossing access
//   o_fault             1-cycle pulse for an illegal funct3
//   o_bus_*             registered bus request, held until i_bus_ack
//   i_bus_ack           beat complete; i_bus_rdata valid in the same cycle
module core_lsu
    import rv_lsu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int ADDR_W      = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_we,
    input  logic [2:0]          i_funct3,
    input  logic [ADDR_W-1:0]   i_addr,
    input  logic [XLEN-1:0]     i_wdata,
    output logic                o_done,
    output logic [XLEN-1:0]     o_rdata,
    output logic                o_misaligned,
    output logic                o_fault,
    output logic                o_bus_req,
    output logic                o_bus_we,
    output logic [ADDR_W-1:0]   o_bus_addr,
    output logic [XLEN/8-1:0]   o_bus_sel,
    output logic [XLEN-1:0]     o_bus_wdata,
    input  logic                i_bus_ack,
    input  logic [XLEN-1:0]     i_bus_rdata
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    lsu_state_t        state, state_n;
    logic              accept;

    logic              we_q;
    logic [2:0]        f3_q;
    logic [OFF_W-1:0]  off_q;
    logic [XLEN-1:0]   wdata_q;
    logic              cross_q;
    logic [XLEN-1:0]   rbuf;

    // The aligner sees the live request while idle (to build beat0) and
    // the held request otherwise (beat1 lanes and load extraction).
    logic              idle;
    logic [2:0]        f3_a;
    logic              we_a;
    logic [OFF_W-1:0]  off_a;
    logic [XLEN-1:0]   wdata_a;
    logic              legal_a;
    logic              cross_a;
    int                span;
    logic [2*NB-1:0]   mask_a;
    logic [2*XLEN-1:0] wsh_a;
    logic [2*XLEN-1:0] rbytes;
    logic [XLEN-1:0]   ext_a;

    assign idle    = (state == IDLE);
    assign f3_a    = idle ? i_funct3 : f3_q;
    assign we_a    = idle ? i_we : we_q;
    assign off_a   = idle ? i_addr[OFF_W-1:0] : off_q;
    assign wdata_a = idle ? i_wdata : wdata_q;
    assign legal_a = is_legal(f3_a, we_a, XLEN);

    always_comb begin
        span    = int'(off_a) + (1 << f3_a[1:0]);
        cross_a = span > NB;
    end

    // On a single-beat completion the word is still on the bus; on a
    // split completion beat0's word sits in rbuf below the live beat1.
    assign rbytes = (state == BEAT0) ? {{XLEN{1'b0}}, i_bus_rdata} : {i_bus_rdata, rbuf};

    core_lsu_align #(.XLEN(XLEN)) u_align (
        .size     (lsu_size_t'(f3_a[1:0])),
        .off      (off_a),
        .wdata    (wdata_a),
        .uns      (f3_a[2]),
        .rbytes   (rbytes),
        .mask     (mask_a),
        .wdata_sh (wsh_a),
        .rdata    (ext_a)
    );

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    accept = 1'b1;
                    if (legal_a && !(cross_a && !MISALIGN_EN)) state_n = BEAT0;
                end
            end
            BEAT0:   if (i_bus_ack) state_n = cross_q ? BEAT1 : RESP;
            BEAT1:   if (i_bus_ack) state_n = RESP;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= IDLE;
            o_ready      <= 1'b1;
            o_done       <= 1'b0;
            o_rdata      <= '0;
            o_misaligned <= 1'b0;
            o_fault      <= 1'b0;
            o_bus_req    <= 1'b0;
            o_bus_we     <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_sel    <= '0;
            o_bus_wdata  <= '0;
            we_q         <= 1'b0;
            f3_q         <= '0;
            off_q        <= '0;
            wdata_q      <= '0;
            cross_q      <= 1'b0;
            rbuf         <= '0;
        end else begin
            state        <= state_n;
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_fault      <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_ready      <= 1'b0;
                        we_q         <= i_we;
                        f3_q         <= i_funct3;
                        off_q        <= i_addr[OFF_W-1:0];
                        wdata_q      <= i_wdata;
                        cross_q      <= cross_a;
                        o_fault      <= !legal_a;
                        o_misaligned <= legal_a && cross_a && !MISALIGN_EN;
                        if (state_n == BEAT0) begin
                            o_bus_req   <= 1'b1;
                            o_bus_we    <= i_we;
                            o_bus_addr  <= {i_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            o_bus_sel   <= mask_a[NB-1:0];
                            o_bus_wdata <= i_we ? wsh_a[XLEN-1:0] : '0;
                        end
                    end else begin
                        // Reopens after a rejection pulse.
                        o_ready <= 1'b1;
                    end
                end
                BEAT0: begin
                    if (i_bus_ack) begin
                        rbuf <= i_bus_rdata;
                        if (cross_q) begin
                            o_bus_addr  <= o_bus_addr + ADDR_W'(NB);
                            o_bus_sel   <= mask_a[2*NB-1:NB];
                            o_bus_wdata <= we_q ? wsh_a[2*XLEN-1:XLEN] : '0;
                        end else begin
                            o_bus_req   <= 1'b0;
                            o_bus_we    <= 1'b0;
                            o_bus_addr  <= '0;
                            o_bus_sel   <= '0;
                            o_bus_wdata <= '0;
                        end
                    end
                end
                BEAT1: begin
                    if (i_bus_ack) begin
                        o_bus_req   <= 1'b0;
                        o_bus_we    <= 1'b0;
                        o_bus_addr  <= '0;
                        o_bus_sel   <= '0;
                        o_bus_wdata <= '0;
                    end
                end
                RESP: begin
                    o_ready <= 1'b1;
                end
                default: begin
                    o_ready <= 1'b1;
                end
            endcase
            // Result is formed on the edge into RESP so o_done and o_rdata
            // appear together; stores leave o_rdata untouched.
            if (state_n == RESP && state != RESP) begin
                o_done <= 1'b1;
                if (!we_q) o_rdata <= ext_a;
            end
        end
    end

endmodule
